program_memory_arbiter: RTL and testbench

//  Shares one single-port synchronous program memory between the instruction-fetch

---
 rtl/program_memory_arbiter_if.sv | 49 ++++
 rtl/program_memory_arbiter.sv | 147 ++++++++++++++
 tb/tb_program_memory_arbiter.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/program_memory_arbiter_if.sv
// Signal bundle between program_memory_arbiter and its neighbours: the fetch
// port, the debug/loader port and the single-port program memory.
interface program_memory_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_W     = 5
);

  logic                  fetch_req;
  logic [DATA_WIDTH-1:0] fetch_addr;
  logic                  fetch_ready;
  logic                  fetch_valid;
  logic [DATA_WIDTH-1:0] fetch_data;
  logic                  fetch_fault;

  logic                  dbg_req;
  logic                  dbg_we;
  logic [DATA_WIDTH-1:0] dbg_addr;
  logic [DATA_WIDTH-1:0] dbg_wdata;
  logic                  dbg_ready;
  logic                  dbg_valid;
  logic [DATA_WIDTH-1:0] dbg_rdata;
  logic                  dbg_fault;

  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // The arbiter side: serves both requesters and masters the memory.
  modport slave (
    input  fetch_req, fetch_addr,
    output fetch_ready, fetch_valid, fetch_data, fetch_fault,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_ready, dbg_valid, dbg_rdata, dbg_fault,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output fetch_req, fetch_addr,
    input  fetch_ready, fetch_valid, fetch_data, fetch_fault,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_ready, dbg_valid, dbg_rdata, dbg_fault,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/program_memory_arbiter.sv
// Round-robin arbiter sharing one program memory between instruction fetch and
// a debug/loader port. Debug writes are only performed when PROGMEM_DBG_WRITE_EN is defined.
module program_memory_arbiter #(
  parameter int                    MEMORY_DEPTH = 32,
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] TEXT_BASE    = 32'h0040_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  program_memory_arbiter_if.slave  bus
);

  localparam int ADDR_W = $clog2(MEMORY_DEPTH);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam logic GRANT_FETCH = 1'b0;
  localparam logic GRANT_DBG   = 1'b1;

  localparam logic [DATA_WIDTH-1:0] DEPTH_WORDS = DATA_WIDTH'(MEMORY_DEPTH);

  logic [1:0]            state;
  logic                  last_grant;
  logic                  cur_dbg;
  logic                  cur_we;
  logic                  cur_fault;
  logic [ADDR_W-1:0]     cur_word;
  logic [DATA_WIDTH-1:0] cur_wdata;

  logic [DATA_WIDTH-1:0] fetch_data_q;
  logic                  fetch_fault_q;
  logic [DATA_WIDTH-1:0] dbg_rdata_q;
  logic                  dbg_fault_q;

  logic                  grant_fetch;
  logic                  grant_dbg;
  logic                  accept;
  logic [DATA_WIDTH-1:0] sel_addr;
  logic                  sel_we;
  logic [DATA_WIDTH-1:0] offset;
  logic [DATA_WIDTH-1:0] word;
  logic                  addr_fault;
  logic                  write_fault;
  logic                  access_ok;
  logic [DATA_WIDTH-1:0] resp_data;

  // On a tie the requester that lost last time wins.
  always_comb begin
    grant_fetch = bus.fetch_req && (!bus.dbg_req || last_grant == GRANT_DBG);
    grant_dbg   = bus.dbg_req && (!bus.fetch_req || last_grant == GRANT_FETCH);
  end

  always_comb begin
    bus.fetch_ready = reset && (state == S_IDLE) && grant_fetch;
    bus.dbg_ready   = reset && (state == S_IDLE) && grant_dbg;
    accept          = bus.fetch_ready || bus.dbg_ready;
  end

  always_comb begin
    sel_addr = grant_dbg ? bus.dbg_addr : bus.fetch_addr;
    sel_we   = grant_dbg && bus.dbg_we;
    offset   = sel_addr - TEXT_BASE;
    word     = offset >> 2;
    addr_fault = (sel_addr < TEXT_BASE) || (sel_addr[1:0] != 2'b00) ||
                 (word >= DEPTH_WORDS);
  end

`ifdef PROGMEM_DBG_WRITE_EN
  assign write_fault = 1'b0;
`else
  // Read-only memory: any debug write is answered with a fault.
  assign write_fault = sel_we;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      last_grant <= GRANT_DBG;
      cur_dbg    <= 1'b0;
      cur_we     <= 1'b0;
      cur_fault  <= 1'b0;
      cur_word   <= '0;
      cur_wdata  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            state      <= S_ACCESS;
            last_grant <= grant_dbg ? GRANT_DBG : GRANT_FETCH;
            cur_dbg    <= grant_dbg;
            cur_we     <= sel_we;
            cur_fault  <= addr_fault || write_fault;
            cur_word   <= word[ADDR_W-1:0];
            cur_wdata  <= grant_dbg ? bus.dbg_wdata : '0;
          end
        end
        S_ACCESS: state <= S_RESP;
        S_RESP:   state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    access_ok     = (state == S_ACCESS) && !cur_fault;
    bus.mem_en    = access_ok;
    bus.mem_addr  = access_ok ? cur_word : '0;
    bus.mem_wdata = (access_ok && cur_we) ? cur_wdata : '0;
`ifdef PROGMEM_DBG_WRITE_EN
    bus.mem_we    = access_ok && cur_we;
`else
    bus.mem_we    = 1'b0;
`endif
  end

  // Response data comes straight from the memory during RESP, then is held.
  always_comb begin
    resp_data       = (cur_fault || cur_we) ? '0 : bus.mem_rdata;
    bus.fetch_valid = (state == S_RESP) && !cur_dbg;
    bus.dbg_valid   = (state == S_RESP) && cur_dbg;
    bus.fetch_data  = bus.fetch_valid ? resp_data : fetch_data_q;
    bus.fetch_fault = bus.fetch_valid ? cur_fault : fetch_fault_q;
    bus.dbg_rdata   = bus.dbg_valid ? resp_data : dbg_rdata_q;
    bus.dbg_fault   = bus.dbg_valid ? cur_fault : dbg_fault_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_data_q  <= '0;
      fetch_fault_q <= 1'b0;
      dbg_rdata_q   <= '0;
      dbg_fault_q   <= 1'b0;
    end else begin
      if (bus.fetch_valid) begin
        fetch_data_q  <= resp_data;
        fetch_fault_q <= cur_fault;
      end
      if (bus.dbg_valid) begin
        dbg_rdata_q <= resp_data;
        dbg_fault_q <= cur_fault;
      end
    end
  end

endmodule

// File: tb/tb_program_memory_arbiter.sv
// Directed bench for program_memory_arbiter with a behavioural program memory;
// memory word i holds 0xC0DE0000 | i until written.
module tb_program_memory_arbiter;

  logic clk = 1'b0;
  logic reset;
  logic mem_clear;
  logic mem_we_seen;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [31:0] store [32];
  logic [31:0] written_mask;

  program_memory_arbiter_if #(.DATA_WIDTH(32), .ADDR_W(5)) bus ();

  program_memory_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Synchronous single-port memory: data appears the cycle after mem_en.
  always_ff @(posedge clk) begin
    if (mem_clear) begin
      written_mask  <= '0;
      bus.mem_rdata <= '0;
      mem_we_seen   <= 1'b0;
    end else if (bus.mem_en) begin
      if (bus.mem_we) begin
        store[bus.mem_addr]        <= bus.mem_wdata;
        written_mask[bus.mem_addr] <= 1'b1;
        mem_we_seen                <= 1'b1;
      end
      bus.mem_rdata <= written_mask[bus.mem_addr] ? store[bus.mem_addr]
                                                   : (32'hC0DE_0000 | 32'(bus.mem_addr));
    end
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic apply_fetch(input string tag, input logic [31:0] addr,
                             input logic [31:0] exp_data, input logic exp_fault,
                             input logic exp_en, input logic [4:0] exp_word);
    @(negedge clk);
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = addr;
    #1;
    check_output({tag, " ready"}, 32'(bus.fetch_ready), 32'd1);
    @(negedge clk);
    bus.fetch_req = 1'b0;
    check_output({tag, " mem_en"}, 32'(bus.mem_en), 32'(exp_en));
    if (exp_en) check_output({tag, " mem_addr"}, 32'(bus.mem_addr), 32'(exp_word));
    check_output({tag, " early valid"}, 32'(bus.fetch_valid), 32'd0);
    @(negedge clk);
    check_output({tag, " valid"}, 32'(bus.fetch_valid), 32'd1);
    check_output({tag, " data"}, bus.fetch_data, exp_data);
    check_output({tag, " fault"}, 32'(bus.fetch_fault), 32'(exp_fault));
    check_output({tag, " resp mem_en"}, 32'(bus.mem_en), 32'd0);
  endtask

  task automatic apply_dbg(input string tag, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp_data,
                           input logic exp_fault, input logic exp_en, input logic exp_we);
    @(negedge clk);
    bus.dbg_req   = 1'b1;
    bus.dbg_we    = we;
    bus.dbg_addr  = addr;
    bus.dbg_wdata = wdata;
    #1;
    check_output({tag, " ready"}, 32'(bus.dbg_ready), 32'd1);
    @(negedge clk);
    bus.dbg_req = 1'b0;
    bus.dbg_we  = 1'b0;
    check_output({tag, " mem_en"}, 32'(bus.mem_en), 32'(exp_en));
    check_output({tag, " mem_we"}, 32'(bus.mem_we), 32'(exp_we));
    @(negedge clk);
    check_output({tag, " valid"}, 32'(bus.dbg_valid), 32'd1);
    check_output({tag, " rdata"}, bus.dbg_rdata, exp_data);
    check_output({tag, " fault"}, 32'(bus.dbg_fault), 32'(exp_fault));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset          = 1'b0;
    mem_clear      = 1'b1;
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 32'h0040_0000;
    bus.dbg_req    = 1'b0;
    bus.dbg_we     = 1'b0;
    bus.dbg_addr   = '0;
    bus.dbg_wdata  = '0;

    // Reset state: no ready even with a pending request, all outputs zero.
    repeat (2) @(negedge clk);
    check_output("reset ready", 32'(bus.fetch_ready), 32'd0);
    check_output("reset valid", 32'(bus.fetch_valid), 32'd0);
    check_output("reset mem_en", 32'(bus.mem_en), 32'd0);
    check_output("reset data", bus.fetch_data, 32'd0);
    bus.fetch_req = 1'b0;
    mem_clear     = 1'b0;
    reset         = 1'b1;

    // Both requesting after reset: F, D, F, D.
    @(negedge clk);
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 32'h0040_0000;
    bus.dbg_req    = 1'b1;
    bus.dbg_addr   = 32'h0040_0004;
    #1;
    for (int k = 0; k < 4; k++) begin
      check_output($sformatf("rr%0d fetch_ready", k), 32'(bus.fetch_ready), 32'(k % 2 == 0));
      check_output($sformatf("rr%0d dbg_ready", k), 32'(bus.dbg_ready), 32'(k % 2 == 1));
      @(negedge clk);
      check_output($sformatf("rr%0d access ready", k),
                   32'(bus.fetch_ready | bus.dbg_ready), 32'd0);
      @(negedge clk);
      if (k % 2 == 0) begin
        check_output($sformatf("rr%0d fetch valid", k), 32'(bus.fetch_valid), 32'd1);
        check_output($sformatf("rr%0d fetch data", k), bus.fetch_data, 32'hC0DE_0000);
      end else begin
        check_output($sformatf("rr%0d dbg valid", k), 32'(bus.dbg_valid), 32'd1);
        check_output($sformatf("rr%0d dbg data", k), bus.dbg_rdata, 32'hC0DE_0001);
      end
      @(negedge clk);
    end
    bus.fetch_req = 1'b0;
    bus.dbg_req   = 1'b0;

    // Plain fetch read, then data holds after the valid pulse.
    apply_fetch("fetch8", 32'h0040_0008, 32'hC0DE_0002, 1'b0, 1'b1, 5'd2);
    @(negedge clk);
    check_output("fetch8 hold valid", 32'(bus.fetch_valid), 32'd0);
    check_output("fetch8 hold data", bus.fetch_data, 32'hC0DE_0002);
    apply_fetch("fetch7c", 32'h0040_007C, 32'hC0DE_001F, 1'b0, 1'b1, 5'd31);

    // Range and alignment faults.
    apply_fetch("below base", 32'h003F_FFFC, 32'd0, 1'b1, 1'b0, 5'd0);
    apply_fetch("misaligned", 32'h0040_0002, 32'd0, 1'b1, 1'b0, 5'd0);
    apply_fetch("past end", 32'h0040_0080, 32'd0, 1'b1, 1'b0, 5'd0);
    @(negedge clk);
    check_output("fault hold", 32'(bus.fetch_fault), 32'd1);

    // Debug write then read back.
`ifdef PROGMEM_DBG_WRITE_EN
    apply_dbg("dbg wr", 1'b1, 32'h0040_0004, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b1, 1'b1);
    apply_dbg("dbg rd", 1'b0, 32'h0040_0004, 32'd0, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0);
`else
    apply_dbg("dbg wr", 1'b1, 32'h0040_0004, 32'hDEAD_BEEF, 32'd0, 1'b1, 1'b0, 1'b0);
    apply_dbg("dbg rd", 1'b0, 32'h0040_0004, 32'd0, 32'hC0DE_0001, 1'b0, 1'b1, 1'b0);
    check_output("mem_we never", 32'(mem_we_seen), 32'd0);
`endif

    // Reset asserted while the memory access is in flight.
    @(negedge clk);
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 32'h0040_0008;
    @(negedge clk);
    bus.fetch_req = 1'b0;
    check_output("rst mem_en before", 32'(bus.mem_en), 32'd1);
    reset = 1'b0;
    #1;
    check_output("rst mem_en", 32'(bus.mem_en), 32'd0);
    check_output("rst mem_addr", 32'(bus.mem_addr), 32'd0);
    @(negedge clk);
    check_output("rst no valid", 32'(bus.fetch_valid), 32'd0);
    check_output("rst data", bus.fetch_data, 32'd0);
    reset = 1'b1;
    apply_fetch("after rst", 32'h0040_000C, 32'hC0DE_0003, 1'b0, 1'b1, 5'd3);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
